decode_exec_pipe: RTL and testbench
===================================

# decode_exec_pipe

Pipeline register between the decode stage and the execution stage. It captures the forwarded rs/rt operands and the decoded control of one instruction per cycle, and presents them to the execution stage. The exec-stage feedback fields that the forwarding logic compares against are driven from this block's registered outputs. It also detects load-use hazards that forwarding cannot resolve, inserts a one-cycle bubble, and handles downstream stall and pipeline flush.

## Interface
- DATA_WIDTH, 32, operand, immediate and PC width
- REG_ADDR_WIDTH, 5, architectural register address width; physical addresses are REG_ADDR_WIDTH+1 bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- dec_valid  in  1  decode holds a real instruction
- dec_rs_enable / dec_rt_enable  in  1  instruction reads rs / rt
- dec_prs_addr / dec_prt_addr  in  REG_ADDR_WIDTH+1  physical source addresses
- dec_rs_override / dec_rt_override  in  DATA_WIDTH  operands after forwarding
- dec_imm, dec_pc  in  DATA_WIDTH  immediate, instruction PC
- dec_alu_op  in  4  ALU operation code
- dec_wb_reg  in  1  instruction writes a register
- dec_exec_src  in  2  result source, shared EX_* encoding
- dec_write_addr  in  REG_ADDR_WIDTH+1  physical destination
- exec_stall  in  1  execution stage cannot accept (multi-cycle op / memory busy)
- flush  in  1  kill the instruction in decode and in this register (branch / exception)
- dec_stall  out  1  decode and fetch must hold their current instruction
- ex_valid  out  1  registered instruction valid
- ex_rs_data, ex_rt_data, ex_imm, ex_pc  out  DATA_WIDTH  registered fields
- ex_alu_op  out  4; ex_wb_reg  out  1; ex_exec_src  out  2; ex_write_addr  out  REG_ADDR_WIDTH+1
- bubble_count  out  32  saturating count of load-use bubbles inserted

## Operation
- Hazard (combinational):
  - Condition: ex_valid & ex_wb_reg & ex_exec_src != EX_ALU & ex_write_addr != 0 & dec_valid & ((dec_rs_enable & dec_prs_addr == ex_write_addr) | (dec_rt_enable & dec_prt_addr == ex_write_addr)).
  - EX_ALU is the only source whose result exists at the end of exec.
- dec_stall = !flush & (exec_stall | hazard).
- Per-edge action, highest priority first:
  1. rst: all ex_* cleared, ex_valid = 0, bubble_count = 0.
  2. flush: ex_valid <= 0 and ex_wb_reg <= 0; other fields are don't-care. Flush overrides exec_stall.
  3. exec_stall: all ex_* hold. No bubble is counted, even if hazard is also true.
  4. hazard: bubble inserted, ex_valid <= 0, ex_wb_reg <= 0. Decode holds through dec_stall. bubble_count += 1, saturating at 0xFFFFFFFF.
  5. Otherwise: all dec_* fields load into ex_*, and ex_valid <= dec_valid. When dec_valid = 0, ex_wb_reg <= 0.
- An invalid ex entry never asserts ex_wb_reg. Downstream forwarding and write-back rely on this.
- Zero destination (address 0) never creates a hazard.

## Timing
- Latency: 1 cycle from decode capture to ex_* valid.
- Load-use costs exactly one bubble:
  - Cycle N: hazard, bubble inserted.
  - Cycle N+1: the load is in mem, so the operand is supplied through mem forwarding, the hazard is clear, and the instruction loads.
- dec_stall is combinational from ex_* registers and inputs. It is never registered.
- Reset mid-operation: outputs clear asynchronously on rst rise. dec_stall reflects only exec_stall while rst is held.
- Simultaneous flush + hazard: flush wins; dec_stall = 0; bubble_count unchanged.

## Test plan
- Reset: assert rst mid-cycle with ex_valid = 1 -> ex_valid = 0, ex_wb_reg = 0, bubble_count = 0 immediately, without waiting for a clock edge.
- Pass-through: dec_valid = 1, rs_override = 0x11, rt = 0x22, pc = 0x400, wb_reg = 1, write_addr = 3, no stalls -> next cycle ex_rs_data = 0x11, ex_rt_data = 0x22, ex_pc = 0x400, ex_valid = 1.
- Load-use: ex holds a load (exec_src != EX_ALU) writing 5; decode reads prs = 5 -> dec_stall = 1 for one cycle, bubble (ex_valid = 0), bubble_count = 1; next cycle the instruction loads.
- ALU result or address 0: same as the load-use case but exec_src = EX_ALU, or write_addr = 0 -> no stall, no bubble.
- exec_stall for 3 cycles with a hazard present -> ex_* hold constant, dec_stall = 1 throughout, bubble_count unchanged.
- Flush with hazard and exec_stall both active -> ex_valid = 0, ex_wb_reg = 0, dec_stall = 0, bubble_count unchanged.

Source files
------------

// File: rtl/decode_exec_pipe_if.sv
// decode_exec_pipe_if
//   Bundle of the signals exchanged between the decode stage, the
//   decode/exec pipeline register and the execution stage.
//
//   master modport : decode/control side. It drives the dec_* fields,
//                    exec_stall and flush. It observes dec_stall, the
//                    registered ex_* fields and bubble_count.
//   slave modport  : the pipeline register (decode_exec_pipe).
//
//   Physical register addresses are REG_ADDR_WIDTH+1 bits wide.
interface decode_exec_pipe_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    localparam int unsigned PADDR_WIDTH = REG_ADDR_WIDTH + 1;

    // decode side
    logic                   dec_valid;
    logic                   dec_rs_enable;
    logic                   dec_rt_enable;
    logic [PADDR_WIDTH-1:0] dec_prs_addr;
    logic [PADDR_WIDTH-1:0] dec_prt_addr;
    logic [DATA_WIDTH-1:0]  dec_rs_override;
    logic [DATA_WIDTH-1:0]  dec_rt_override;
    logic [DATA_WIDTH-1:0]  dec_imm;
    logic [DATA_WIDTH-1:0]  dec_pc;
    logic [3:0]             dec_alu_op;
    logic                   dec_wb_reg;
    logic [1:0]             dec_exec_src;
    logic [PADDR_WIDTH-1:0] dec_write_addr;

    // pipeline control
    logic                   exec_stall;
    logic                   flush;
    logic                   dec_stall;

    // execution side
    logic                   ex_valid;
    logic [DATA_WIDTH-1:0]  ex_rs_data;
    logic [DATA_WIDTH-1:0]  ex_rt_data;
    logic [DATA_WIDTH-1:0]  ex_imm;
    logic [DATA_WIDTH-1:0]  ex_pc;
    logic [3:0]             ex_alu_op;
    logic                   ex_wb_reg;
    logic [1:0]             ex_exec_src;
    logic [PADDR_WIDTH-1:0] ex_write_addr;
    logic [31:0]            bubble_count;

    modport master (
        output dec_valid, dec_rs_enable, dec_rt_enable,
               dec_prs_addr, dec_prt_addr,
               dec_rs_override, dec_rt_override,
               dec_imm, dec_pc, dec_alu_op, dec_wb_reg,
               dec_exec_src, dec_write_addr,
               exec_stall, flush,
        input  dec_stall,
               ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_pc,
               ex_alu_op, ex_wb_reg, ex_exec_src, ex_write_addr,
               bubble_count
    );

    modport slave (
        input  dec_valid, dec_rs_enable, dec_rt_enable,
               dec_prs_addr, dec_prt_addr,
               dec_rs_override, dec_rt_override,
               dec_imm, dec_pc, dec_alu_op, dec_wb_reg,
               dec_exec_src, dec_write_addr,
               exec_stall, flush,
        output dec_stall,
               ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_pc,
               ex_alu_op, ex_wb_reg, ex_exec_src, ex_write_addr,
               bubble_count
    );
endinterface

// File: rtl/decode_exec_pipe.sv
// decode_exec_pipe
//   Pipeline register between decode and execute. It captures the
//   forwarded operands and the decoded control of one instruction per
//   cycle. It also detects load-use hazards that forwarding cannot cover
//   and resolves each one with a single bubble. Downstream stall and
//   flush are handled here as well.
//
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : decode_exec_pipe_if.slave carrying dec_*, exec_stall,
//            flush, dec_stall, ex_* and bubble_count
//
//   Priority per edge: rst > flush > exec_stall > hazard bubble > load.
//   An entry that is not valid never has ex_wb_reg set, so the forwarding
//   and write-back logic may use ex_wb_reg without also checking ex_valid.
module decode_exec_pipe #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input logic               clk,
    input logic               rst,
    decode_exec_pipe_if.slave bus
);
    localparam int unsigned PADDR_WIDTH = REG_ADDR_WIDTH + 1;

    // Shared result-source encoding. Only EX_ALU produces its result by
    // the end of exec. Every other source finishes later, so a dependent
    // instruction right behind it cannot be fed by forwarding.
    typedef enum logic [1:0] {
        EX_ALU  = 2'd0,
        EX_LOAD = 2'd1,
        EX_MUL  = 2'd2,
        EX_CSR  = 2'd3
    } exec_src_t;

    logic                   ex_valid_q;
    logic [DATA_WIDTH-1:0]  ex_rs_data_q;
    logic [DATA_WIDTH-1:0]  ex_rt_data_q;
    logic [DATA_WIDTH-1:0]  ex_imm_q;
    logic [DATA_WIDTH-1:0]  ex_pc_q;
    logic [3:0]             ex_alu_op_q;
    logic                   ex_wb_reg_q;
    exec_src_t              ex_exec_src_q;
    logic [PADDR_WIDTH-1:0] ex_write_addr_q;
    logic [31:0]            bubble_count_q;

    logic rs_hit;
    logic rt_hit;
    logic late_result;
    logic hazard;

    // Load-use detection. ex_valid is redundant with ex_wb_reg, but it is
    // kept so the check stays correct if that invariant is ever relaxed.
    always_comb begin
        rs_hit      = bus.dec_rs_enable && (bus.dec_prs_addr == ex_write_addr_q);
        rt_hit      = bus.dec_rt_enable && (bus.dec_prt_addr == ex_write_addr_q);
        late_result = ex_valid_q && ex_wb_reg_q
                      && (ex_exec_src_q != EX_ALU)
                      && (ex_write_addr_q != '0);
        hazard      = late_result && bus.dec_valid && (rs_hit || rt_hit);
    end

    // Flush discards the decode instruction, so decode never has to hold
    // it, even while exec is stalled.
    assign bus.dec_stall = !bus.flush && (bus.exec_stall || hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_rs_data_q    <= '0;
            ex_rt_data_q    <= '0;
            ex_imm_q        <= '0;
            ex_pc_q         <= '0;
            ex_alu_op_q     <= '0;
            ex_wb_reg_q     <= 1'b0;
            ex_exec_src_q   <= EX_ALU;
            ex_write_addr_q <= '0;
            bubble_count_q  <= '0;
        end else if (bus.flush) begin
            ex_valid_q  <= 1'b0;
            ex_wb_reg_q <= 1'b0;
        end else if (bus.exec_stall) begin
            // hold everything; a pending hazard is not counted here
        end else if (hazard) begin
            ex_valid_q  <= 1'b0;
            ex_wb_reg_q <= 1'b0;
            if (bubble_count_q != '1) begin
                bubble_count_q <= bubble_count_q + 32'd1;
            end
        end else begin
            ex_valid_q      <= bus.dec_valid;
            ex_rs_data_q    <= bus.dec_rs_override;
            ex_rt_data_q    <= bus.dec_rt_override;
            ex_imm_q        <= bus.dec_imm;
            ex_pc_q         <= bus.dec_pc;
            ex_alu_op_q     <= bus.dec_alu_op;
            ex_wb_reg_q     <= bus.dec_valid && bus.dec_wb_reg;
            ex_exec_src_q   <= exec_src_t'(bus.dec_exec_src);
            ex_write_addr_q <= bus.dec_write_addr;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_rs_data    = ex_rs_data_q;
    assign bus.ex_rt_data    = ex_rt_data_q;
    assign bus.ex_imm        = ex_imm_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.ex_alu_op     = ex_alu_op_q;
    assign bus.ex_wb_reg     = ex_wb_reg_q;
    assign bus.ex_exec_src   = ex_exec_src_q;
    assign bus.ex_write_addr = ex_write_addr_q;
    assign bus.bubble_count  = bubble_count_q;
endmodule

// File: tb/tb_decode_exec_pipe.sv
// tb_decode_exec_pipe
//   Directed bench for decode_exec_pipe. Inputs are driven 1 time unit
//   after the rising edge. Registered outputs are sampled at that same
//   point, and combinational dec_stall is sampled 1 unit after the inputs
//   settle.
module tb_decode_exec_pipe;
    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LOAD = 2'd1;

    logic clk;
    logic rst;
    int unsigned errors;
    int unsigned checks;

    decode_exec_pipe_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    decode_exec_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dec_valid       = 1'b0;
        bus.dec_rs_enable   = 1'b0;
        bus.dec_rt_enable   = 1'b0;
        bus.dec_prs_addr    = '0;
        bus.dec_prt_addr    = '0;
        bus.dec_rs_override = '0;
        bus.dec_rt_override = '0;
        bus.dec_imm         = '0;
        bus.dec_pc          = '0;
        bus.dec_alu_op      = '0;
        bus.dec_wb_reg      = 1'b0;
        bus.dec_exec_src    = SRC_ALU;
        bus.dec_write_addr  = '0;
        bus.exec_stall      = 1'b0;
        bus.flush           = 1'b0;
    endtask

    // Drive one valid writing instruction (no source reads) into decode.
    task automatic put_producer(input logic [1:0] src, input logic [5:0] waddr,
                                input logic [31:0] rs, input logic [31:0] pc);
        idle();
        bus.dec_valid       = 1'b1;
        bus.dec_wb_reg      = 1'b1;
        bus.dec_exec_src    = src;
        bus.dec_write_addr  = waddr;
        bus.dec_rs_override = rs;
        bus.dec_pc          = pc;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_valid", {31'd0, bus.ex_valid}, 32'd0);
        check_eq("reset_wb", {31'd0, bus.ex_wb_reg}, 32'd0);
        check_eq("reset_bubbles", bus.bubble_count, 32'd0);

        // pass-through
        idle();
        bus.dec_valid = 1'b1; bus.dec_rs_enable = 1'b1; bus.dec_prs_addr = 6'd1;
        bus.dec_rs_override = 32'h11; bus.dec_rt_override = 32'h22;
        bus.dec_pc = 32'h400; bus.dec_imm = 32'h7; bus.dec_alu_op = 4'h3;
        bus.dec_wb_reg = 1'b1; bus.dec_write_addr = 6'd3;
        #1 check_eq("pass_stall", {31'd0, bus.dec_stall}, 32'd0);
        tick();
        check_eq("pass_rs", bus.ex_rs_data, 32'h11);
        check_eq("pass_rt", bus.ex_rt_data, 32'h22);
        check_eq("pass_pc", bus.ex_pc, 32'h400);
        check_eq("pass_imm", bus.ex_imm, 32'h7);
        check_eq("pass_op", {28'd0, bus.ex_alu_op}, 32'h3);
        check_eq("pass_valid", {31'd0, bus.ex_valid}, 32'd1);
        check_eq("pass_wb", {31'd0, bus.ex_wb_reg}, 32'd1);
        check_eq("pass_waddr", {26'd0, bus.ex_write_addr}, 32'd3);

        // load-use on rs: one bubble, then the dependent instruction loads
        put_producer(SRC_LOAD, 6'd5, 32'hAA, 32'h404);
        tick();
        check_eq("load_src", {30'd0, bus.ex_exec_src}, {30'd0, SRC_LOAD});
        idle();
        bus.dec_valid = 1'b1; bus.dec_rs_enable = 1'b1; bus.dec_prs_addr = 6'd5;
        bus.dec_rs_override = 32'h55; bus.dec_pc = 32'h408;
        bus.dec_wb_reg = 1'b1; bus.dec_write_addr = 6'd6;
        #1 check_eq("lu_stall", {31'd0, bus.dec_stall}, 32'd1);
        tick();
        check_eq("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        check_eq("lu_bubble_wb", {31'd0, bus.ex_wb_reg}, 32'd0);
        check_eq("lu_count", bus.bubble_count, 32'd1);
        bus.dec_rs_override = 32'h77;   // now supplied by mem forwarding
        #1 check_eq("lu_stall_clear", {31'd0, bus.dec_stall}, 32'd0);
        tick();
        check_eq("lu_load_valid", {31'd0, bus.ex_valid}, 32'd1);
        check_eq("lu_load_rs", bus.ex_rs_data, 32'h77);
        check_eq("lu_load_pc", bus.ex_pc, 32'h408);
        check_eq("lu_count_hold", bus.bubble_count, 32'd1);

        // ex holds an ALU op writing 6: reading 6 is not a hazard
        idle();
        bus.dec_valid = 1'b1; bus.dec_rs_enable = 1'b1; bus.dec_prs_addr = 6'd6;
        bus.dec_rs_override = 32'h66;
        #1 check_eq("alu_no_stall", {31'd0, bus.dec_stall}, 32'd0);
        tick();
        check_eq("alu_valid", {31'd0, bus.ex_valid}, 32'd1);
        check_eq("alu_count", bus.bubble_count, 32'd1);

        // load to address 0 never creates a hazard
        put_producer(SRC_LOAD, 6'd0, 32'h0, 32'h500);
        tick();
        idle();
        bus.dec_valid = 1'b1; bus.dec_rs_enable = 1'b1; bus.dec_rt_enable = 1'b1;
        #1 check_eq("zero_no_stall", {31'd0, bus.dec_stall}, 32'd0);
        tick();
        check_eq("zero_count", bus.bubble_count, 32'd1);

        // enables gate the match; rt alone can cause the hazard
        put_producer(SRC_LOAD, 6'd9, 32'h0, 32'h600);
        tick();
        idle();
        bus.dec_valid = 1'b1; bus.dec_prs_addr = 6'd9; bus.dec_prt_addr = 6'd9;
        #1 check_eq("noen_no_stall", {31'd0, bus.dec_stall}, 32'd0);
        bus.dec_rt_enable = 1'b1;
        #1 check_eq("rt_stall", {31'd0, bus.dec_stall}, 32'd1);
        tick();
        check_eq("rt_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        check_eq("rt_count", bus.bubble_count, 32'd2);

        // exec_stall for 3 cycles with a hazard pending: hold, no bubble
        put_producer(SRC_LOAD, 6'd5, 32'hBEEF, 32'h700);
        tick();
        idle();
        bus.dec_valid = 1'b1; bus.dec_rs_enable = 1'b1; bus.dec_prs_addr = 6'd5;
        bus.dec_rs_override = 32'h1234; bus.exec_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("xs_stall", {31'd0, bus.dec_stall}, 32'd1);
            tick();
            check_eq("xs_rs_hold", bus.ex_rs_data, 32'hBEEF);
            check_eq("xs_pc_hold", bus.ex_pc, 32'h700);
            check_eq("xs_valid_hold", {31'd0, bus.ex_valid}, 32'd1);
            check_eq("xs_count", bus.bubble_count, 32'd2);
        end

        // flush with hazard and exec_stall both active
        bus.flush = 1'b1;
        #1 check_eq("fl_stall", {31'd0, bus.dec_stall}, 32'd0);
        tick();
        check_eq("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
        check_eq("fl_wb", {31'd0, bus.ex_wb_reg}, 32'd0);
        check_eq("fl_count", bus.bubble_count, 32'd2);

        // invalid decode never carries wb_reg into ex
        idle();
        bus.dec_wb_reg = 1'b1; bus.dec_write_addr = 6'd4;
        tick();
        check_eq("inv_valid", {31'd0, bus.ex_valid}, 32'd0);
        check_eq("inv_wb", {31'd0, bus.ex_wb_reg}, 32'd0);

        // asynchronous reset mid-cycle with a valid entry held
        put_producer(SRC_ALU, 6'd7, 32'h99, 32'h800);
        tick();
        check_eq("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
        idle();
        bus.exec_stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, bus.ex_valid}, 32'd0);
        check_eq("arst_wb", {31'd0, bus.ex_wb_reg}, 32'd0);
        check_eq("arst_count", bus.bubble_count, 32'd0);
        check_eq("arst_stall", {31'd0, bus.dec_stall}, 32'd1);
        rst = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
